game_flow_control: RTL and testbench

GAME_FLOW_CONTROL -- requirements
Module: game_flow_control

---
 rtl/game_flow_control_pkg.sv | 15 +
 rtl/game_flow_control_if.sv | 34 +++
 rtl/edge_detect_rise.sv | 19 +
 rtl/game_flow_control.sv | 165 ++++++++++++++++
 tb/tb_game_flow_control.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_control_pkg.sv
// Shared types and default constants for the game flow controller.
package game_flow_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_PLAY,
        ST_LEVEL_UP,
        ST_GAME_OVER
    } state_e;

    localparam int LIFE_INIT_DEF = 3;
    localparam int LIFE_MAX_DEF  = 9;

endpackage

// File: rtl/game_flow_control_if.sv
// Player/collision inputs and game status outputs of the flow controller.
interface game_flow_control_if #(
    parameter int SCORE_W = 16,
    parameter int LIFE_W  = 4,
    parameter int LEVEL_W = 3
);
    logic               start;
    logic               key5IsPressed;
    logic               collisionBallObstacle;
    logic               collisionBallObstacleGood;
    logic               collisionBallObstacleBad;
    logic               collisionBallCredit;
    logic               collisionBallBottom;
    logic               pause;
    logic               reset_level;
    logic               reset_level_pulse;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic [LIFE_W-1:0]  life;
    logic [LEVEL_W-1:0] level;

    modport master (
        output start, key5IsPressed, collisionBallObstacle, collisionBallObstacleGood,
               collisionBallObstacleBad, collisionBallCredit, collisionBallBottom,
        input  pause, reset_level, reset_level_pulse, game_over, score, high_score, life, level
    );

    modport slave (
        input  start, key5IsPressed, collisionBallObstacle, collisionBallObstacleGood,
               collisionBallObstacleBad, collisionBallCredit, collisionBallBottom,
        output pause, reset_level, reset_level_pulse, game_over, score, high_score, life, level
    );
endinterface

// File: rtl/edge_detect_rise.sv
// One-cycle strobe on each rising edge of d.
module edge_detect_rise (
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic pulse
);
    logic d_d;
    logic d_q;

    always_comb d_d = d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) d_q <= 1'b0;
        else         d_q <= d_d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/game_flow_control.sv
// Game state machine: lives, score, high score, level progression and bonus lives.
module game_flow_control
    import game_flow_control_pkg::*;
#(
    parameter int SCORE_W        = 16,
    parameter int LIFE_W         = 4,
    parameter int LIFE_INIT      = LIFE_INIT_DEF,
    parameter int LIFE_MAX       = LIFE_MAX_DEF,
    parameter int LEVEL_W        = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int GOOD_POINTS    = 1,
    parameter int CREDIT_POINTS  = 2,
    parameter int BAD_PENALTY    = 1,
    parameter int LEVEL_UP_SCORE = 10,
    parameter int BONUS_EVERY    = 20
) (
    input logic          clk,
    input logic          resetN,
    game_flow_control_if.slave gif
);
    localparam logic [SCORE_W-1:0] GOOD_G     = SCORE_W'(GOOD_POINTS);
    localparam logic [SCORE_W-1:0] CREDIT_G   = SCORE_W'(CREDIT_POINTS);
    localparam logic [SCORE_W-1:0] BAD_G      = SCORE_W'(BAD_PENALTY);
    localparam logic [SCORE_W-1:0] LVL_STEP   = SCORE_W'(LEVEL_UP_SCORE);
    localparam logic [SCORE_W-1:0] BONUS_STEP = SCORE_W'(BONUS_EVERY);
    localparam logic [LIFE_W-1:0]  LIFE_START = LIFE_W'(LIFE_INIT);
    localparam logic [LIFE_W-1:0]  LIFE_CEIL  = LIFE_W'(LIFE_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        return (a > ~b) ? '1 : a + b;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        return (a >= b) ? a - b : '0;
    endfunction

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d;
    logic [SCORE_W-1:0] lvl_acc_q, lvl_acc_d, bon_acc_q, bon_acc_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] gain, lvl_sum, bon_sum;
    logic               pause, reset_level, game_over;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        high_d    = high_q;
        life_d    = life_q;
        level_d   = level_q;
        lvl_acc_d = lvl_acc_q;
        bon_acc_d = bon_acc_q;
        gain      = '0;
        lvl_sum   = '0;
        bon_sum   = '0;
        case (state_q)
            ST_IDLE:  if (gif.start) state_d = ST_READY;
            ST_READY: if (gif.key5IsPressed) state_d = ST_PLAY;
            ST_PLAY: begin
                // Losing the ball outranks every hit in the same cycle.
                if (gif.collisionBallBottom) begin
                    life_d = (life_q == '0) ? '0 : life_q - 1'b1;
                    if (life_q <= LIFE_W'(1)) begin
                        state_d = ST_GAME_OVER;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else begin
                        state_d = ST_READY;
                    end
                end else if (gif.collisionBallObstacle && gif.collisionBallObstacleGood) begin
                    gain = GOOD_G;
                end else if (gif.collisionBallCredit) begin
                    gain = CREDIT_G;
                end else if (gif.collisionBallObstacle && gif.collisionBallObstacleBad) begin
                    score_d = sat_sub(score_q, BAD_G);
                end
                if (gain != '0) begin
                    score_d = sat_add(score_q, gain);
                    bon_sum = bon_acc_q + gain;
                    if (bon_sum >= BONUS_STEP) begin
                        bon_sum = bon_sum - BONUS_STEP;
                        if (life_q < LIFE_CEIL) life_d = life_q + 1'b1;
                    end
                    bon_acc_d = bon_sum;
                    lvl_sum   = lvl_acc_q + gain;
                    if (lvl_sum >= LVL_STEP) begin
                        if (level_q < LEVEL_LAST) begin
                            lvl_sum = lvl_sum - LVL_STEP;
                            level_d = level_q + 1'b1;
                            state_d = ST_LEVEL_UP;
                        end else begin
                            lvl_sum = '0;
                        end
                    end
                    lvl_acc_d = lvl_sum;
                end
            end
            ST_LEVEL_UP: if (gif.key5IsPressed) state_d = ST_PLAY;
            ST_GAME_OVER: begin
                if (gif.key5IsPressed) begin
                    state_d   = ST_READY;
                    score_d   = '0;
                    life_d    = LIFE_START;
                    level_d   = '0;
                    lvl_acc_d = '0;
                    bon_acc_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pause       = 1'b1;
        reset_level = 1'b0;
        game_over   = 1'b0;
        case (state_q)
            ST_READY:     reset_level = 1'b1;
            ST_PLAY:      pause       = 1'b0;
            ST_LEVEL_UP:  reset_level = 1'b1;
            ST_GAME_OVER: begin
                reset_level = 1'b1;
                game_over   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            high_q    <= '0;
            life_q    <= LIFE_START;
            level_q   <= '0;
            lvl_acc_q <= '0;
            bon_acc_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            life_q    <= life_d;
            level_q   <= level_d;
            lvl_acc_q <= lvl_acc_d;
            bon_acc_q <= bon_acc_d;
        end
    end

    edge_detect_rise u_rl_edge (
        .clk    (clk),
        .resetN (resetN),
        .d      (reset_level),
        .pulse  (gif.reset_level_pulse)
    );

    assign gif.pause       = pause;
    assign gif.reset_level = reset_level;
    assign gif.game_over   = game_over;
    assign gif.score       = score_q;
    assign gif.high_score  = high_q;
    assign gif.life        = life_q;
    assign gif.level       = level_q;
endmodule

// File: tb/tb_game_flow_control.sv
// Directed bench for game_flow_control: lives, scoring, level-up, bonus, high score, reset.
module tb_game_flow_control;
    localparam int EV_START  = 1;
    localparam int EV_KEY5   = 2;
    localparam int EV_BOTTOM = 3;
    localparam int EV_GOOD   = 4;
    localparam int EV_CREDIT = 5;
    localparam int EV_BAD    = 6;
    localparam int EV_TRIPLE = 7;

    logic clk = 1'b0;
    logic resetN;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    int   p0;

    always #5 clk = ~clk;

    game_flow_control_if gif ();

    game_flow_control u_dut (
        .clk    (clk),
        .resetN (resetN),
        .gif    (gif)
    );

    always @(negedge clk) begin
        if (gif.reset_level_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        gif.start                     = 1'b0;
        gif.key5IsPressed             = 1'b0;
        gif.collisionBallObstacle     = 1'b0;
        gif.collisionBallObstacleGood = 1'b0;
        gif.collisionBallObstacleBad  = 1'b0;
        gif.collisionBallCredit       = 1'b0;
        gif.collisionBallBottom       = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one event for a single clock, then release all inputs.
    task automatic hit(input int kind);
        case (kind)
            EV_START:  gif.start = 1'b1;
            EV_KEY5:   gif.key5IsPressed = 1'b1;
            EV_BOTTOM: gif.collisionBallBottom = 1'b1;
            EV_GOOD: begin
                gif.collisionBallObstacle     = 1'b1;
                gif.collisionBallObstacleGood = 1'b1;
            end
            EV_CREDIT: gif.collisionBallCredit = 1'b1;
            EV_BAD: begin
                gif.collisionBallObstacle    = 1'b1;
                gif.collisionBallObstacleBad = 1'b1;
            end
            EV_TRIPLE: begin
                gif.collisionBallBottom       = 1'b1;
                gif.collisionBallObstacle     = 1'b1;
                gif.collisionBallObstacleGood = 1'b1;
                gif.collisionBallCredit       = 1'b1;
            end
            default: ;
        endcase
        cycle();
        clear_inputs();
    endtask

    // From PLAY with three lives: lose them all, relaunching in between.
    task automatic lose_game();
        hit(EV_BOTTOM);
        repeat (2) begin
            hit(EV_KEY5);
            hit(EV_BOTTOM);
        end
    endtask

    initial begin
        clear_inputs();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pause", gif.pause, 1);
        check_val("rst_reset_level", gif.reset_level, 0);
        check_val("rst_pulse", gif.reset_level_pulse, 0);
        check_val("rst_game_over", gif.game_over, 0);
        check_val("rst_score", gif.score, 0);
        check_val("rst_high", gif.high_score, 0);
        check_val("rst_life", gif.life, 3);
        check_val("rst_level", gif.level, 0);
        resetN = 1'b1;
        cycle();

        // Three ball losses end the game
        hit(EV_KEY5);
        check_val("idle_ignores_key5", gif.reset_level, 0);
        hit(EV_START);
        check_val("ready_reset_level", gif.reset_level, 1);
        check_val("ready_pause", gif.pause, 1);
        hit(EV_KEY5);
        check_val("play_pause", gif.pause, 0);
        p0 = pulse_cnt;
        hit(EV_BOTTOM);
        check_val("life_after_1", gif.life, 2);
        check_val("ready_after_1", gif.reset_level, 1);
        hit(EV_KEY5);
        hit(EV_BOTTOM);
        check_val("life_after_2", gif.life, 1);
        hit(EV_KEY5);
        hit(EV_BOTTOM);
        check_val("life_after_3", gif.life, 0);
        check_val("game_over_flag", gif.game_over, 1);
        check_val("game_over_high", gif.high_score, 0);
        cycle();
        check_val("loss_pulses", pulse_cnt - p0, 3);

        // High score retained across restarts
        hit(EV_KEY5);
        check_val("restart_score", gif.score, 0);
        check_val("restart_life", gif.life, 3);
        check_val("restart_game_over", gif.game_over, 0);
        check_val("restart_ready", gif.reset_level, 1);
        hit(EV_KEY5);
        repeat (3) hit(EV_CREDIT);
        hit(EV_GOOD);
        check_val("score_7", gif.score, 7);
        lose_game();
        check_val("go1_flag", gif.game_over, 1);
        check_val("go1_high", gif.high_score, 7);
        hit(EV_KEY5);
        check_val("restart2_high", gif.high_score, 7);
        check_val("restart2_score", gif.score, 0);
        hit(EV_KEY5);
        hit(EV_CREDIT);
        hit(EV_GOOD);
        check_val("score_3", gif.score, 3);
        lose_game();
        check_val("go2_flag", gif.game_over, 1);
        check_val("go2_high", gif.high_score, 7);
        resetN = 1'b0;
        #2;
        check_val("rst_clears_high", gif.high_score, 0);
        check_val("rst_clears_score", gif.score, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cycle();

        // Penalty floor and accumulators untouched by penalties
        hit(EV_START);
        hit(EV_KEY5);
        hit(EV_BAD);
        check_val("bad_floor", gif.score, 0);
        repeat (5) hit(EV_GOOD);
        check_val("good_x5", gif.score, 5);
        hit(EV_BAD);
        check_val("bad_from_5", gif.score, 4);
        repeat (4) hit(EV_GOOD);
        check_val("score_8", gif.score, 8);
        check_val("level_still_0", gif.level, 0);
        hit(EV_GOOD);
        check_val("score_9", gif.score, 9);
        check_val("level_up_at_acc_10", gif.level, 1);
        check_val("level_up_reset_level", gif.reset_level, 1);
        check_val("level_up_pause", gif.pause, 1);
        hit(EV_CREDIT);
        check_val("level_up_ignores_hit", gif.score, 9);
        hit(EV_START);
        check_val("level_up_ignores_start", gif.reset_level, 1);
        hit(EV_KEY5);
        check_val("resume_pause", gif.pause, 0);
        hit(EV_TRIPLE);
        check_val("triple_life", gif.life, 2);
        check_val("triple_score", gif.score, 9);
        check_val("triple_ready", gif.reset_level, 1);
        hit(EV_KEY5);
        repeat (3) hit(EV_GOOD);
        check_val("score_12", gif.score, 12);
        check_val("level_1_mid", gif.level, 1);
        resetN = 1'b0;
        #2;
        check_val("midrst_pause", gif.pause, 1);
        check_val("midrst_reset_level", gif.reset_level, 0);
        check_val("midrst_score", gif.score, 0);
        check_val("midrst_level", gif.level, 0);
        check_val("midrst_life", gif.life, 3);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cycle();
        hit(EV_CREDIT);
        check_val("idle_ignores_hit", gif.score, 0);

        // Credit run: two level-ups and a bonus life on the tenth hit
        hit(EV_START);
        hit(EV_KEY5);
        p0 = pulse_cnt;
        repeat (4) hit(EV_CREDIT);
        check_val("credit_x4_score", gif.score, 8);
        check_val("credit_x4_level", gif.level, 0);
        check_val("credit_x4_play", gif.pause, 0);
        hit(EV_CREDIT);
        check_val("credit_x5_score", gif.score, 10);
        check_val("credit_x5_level", gif.level, 1);
        check_val("credit_x5_level_up", gif.reset_level, 1);
        check_val("credit_x5_life", gif.life, 3);
        cycle();
        check_val("credit_x5_pulses", pulse_cnt - p0, 1);
        hit(EV_KEY5);
        repeat (4) hit(EV_CREDIT);
        check_val("credit_x9_score", gif.score, 18);
        check_val("credit_x9_life", gif.life, 3);
        hit(EV_CREDIT);
        check_val("credit_x10_score", gif.score, 20);
        check_val("credit_x10_life", gif.life, 4);
        check_val("credit_x10_level", gif.level, 2);
        check_val("credit_x10_level_up", gif.reset_level, 1);
        cycle();
        check_val("credit_x10_pulses", pulse_cnt - p0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
